// File: rtl/jtframe_sdram_sched.sv
// Round-robin SDRAM read scheduler for four level-request slots.
// One read in flight; watchdog on data return; refresh when idle.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   downloading         blocks new grants while high
//   slot_req/slot_addr  per-slot request level and address
//   slot_ok/slot_dout   one-cycle done pulse, shared data word
//   sdram_req/addr/ack  request handshake to the SDRAM controller
//   data_rdy/data_read  returned data from the controller
//   refresh_en, busy    idle-refresh permission, transaction flag
module jtframe_sdram_sched #(
  parameter int AW   = 22,
  parameter int TOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            downloading,
  input  logic [3:0]      slot_req,
  input  logic [4*AW-1:0] slot_addr,
  output logic [3:0]      slot_ok,
  output logic [31:0]     slot_dout,
  output logic            sdram_req,
  output logic [AW-1:0]   sdram_addr,
  input  logic            sdram_ack,
  input  logic            data_rdy,
  input  logic [31:0]     data_read,
  output logic            refresh_en,
  output logic            busy
);

  localparam int WW = $clog2(TOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    grant, grant_nx;
  logic [1:0]    last, last_nx;
  logic [1:0]    pick;
  logic          hit;
  logic [AW-1:0] addr_sel, addr_nx;
  logic          req_nx;
  logic [3:0]    ok_nx;
  logic [31:0]   dout_nx;
  logic [WW-1:0] wd, wd_nx, wd_inc;

  // Search starts one past the last completed grant.
  always_comb begin : rr
    logic [1:0] idx;
    pick = last;
    hit  = 1'b0;
    idx  = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!hit && slot_req[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  always_comb begin
    unique case (pick)
      2'd0: addr_sel = slot_addr[0*AW +: AW];
      2'd1: addr_sel = slot_addr[1*AW +: AW];
      2'd2: addr_sel = slot_addr[2*AW +: AW];
      2'd3: addr_sel = slot_addr[3*AW +: AW];
      default: addr_sel = '0;
    endcase
  end

  assign wd_inc = wd + 1'b1;

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx  = last;
    addr_nx  = sdram_addr;
    req_nx   = sdram_req;
    ok_nx    = 4'b0000;
    dout_nx  = slot_dout;
    wd_nx    = wd;
    unique case (state)
      IDLE: begin
        if (!downloading && hit) begin
          grant_nx = pick;
          addr_nx  = addr_sel;
          req_nx   = 1'b1;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          req_nx = 1'b0;
          if (data_rdy) begin
            dout_nx  = data_read;
            ok_nx    = 4'b0001 << grant;
            last_nx  = grant;
            state_nx = IDLE;
          end else begin
            wd_nx    = '0;
            state_nx = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (data_rdy) begin
          dout_nx  = data_read;
          ok_nx    = 4'b0001 << grant;
          last_nx  = grant;
          state_nx = IDLE;
        end else if (wd_inc == WW'(TOUT)) begin
          // Timed-out slot goes to the back of the rotation.
          wd_nx    = wd_inc;
          last_nx  = grant;
          state_nx = IDLE;
        end else begin
          wd_nx = wd_inc;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last       <= 2'd3;
      sdram_addr <= '0;
      sdram_req  <= 1'b0;
      slot_ok    <= 4'b0000;
      slot_dout  <= 32'd0;
      wd         <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last       <= last_nx;
      sdram_addr <= addr_nx;
      sdram_req  <= req_nx;
      slot_ok    <= ok_nx;
      slot_dout  <= dout_nx;
      wd         <= wd_nx;
    end
  end

  assign busy = (state != IDLE);
  assign refresh_en = (state == IDLE) &&
                      ((slot_req == 4'b0000) || downloading);

endmodule
